ws2812_strip_sequencer: RTL and testbench
=========================================

// Module: ws2812_strip_sequencer
// PURPOSE
//   Frame-level driver sitting directly upstream of BitController. Holds a
//   NUM_LEDS x 24-bit pixel buffer, and on start streams each pixel word to
//   BitController (bit_data + bit_load), waiting on bit_done between words.
//   After the last pixel it holds the line idle for the WS2812 latch period,
//   then signals frame_done.
// PARAMETERS
//   F_CLK     12_000_000  system clock frequency, Hz
//   NUM_LEDS  8           pixels per strip (>=1)
//   LATCH_US  300         post-frame idle time, us; LATCH_CYC = F_CLK/1_000_000*LATCH_US
// PORTS
//   clk         in   1   system clock, all logic on rising edge
//   reset       in   1   asynchronous, active-high reset
//   wr_en       in   1   pixel buffer write strobe
//   wr_addr     in   AW  pixel index, AW = max(1,$clog2(NUM_LEDS))
//   wr_data     in   24  pixel word, GRB order, passed through unmodified
//   start       in   1   request one frame; sampled only in IDLE
//   bit_data    out  24  word to BitController; stable from bit_load until next bit_load
//   bit_load    out  1   1-cycle pulse: BitController loads bit_data and starts
//   bit_done    in   1   BitController idle/finished (high), low while shifting
//   busy        out  1   high in every state except IDLE
//   frame_done  out  1   1-cycle pulse at end of latch period
// BEHAVIOUR
//   Reset: bit_data=0, bit_load=0, busy=0, frame_done=0, idx=0,
//     latch counter=0, pixel buffer cleared to 0, state=IDLE. Reset asserted
//     mid-frame aborts immediately; the frame is not resumed.
//   Buffer: write on wr_en when wr_addr<NUM_LEDS; out-of-range writes ignored.
//     Writes are accepted in any state. A write to a pixel not yet loaded this
//     frame is sent this frame; a write to an already-loaded pixel (including
//     the current one) takes effect next frame. bit_data is a register.
//   FSM (all outputs registered):
//     IDLE      : start=1 -> LOAD, idx=0. Otherwise stay.
//     LOAD      : bit_data<=buf[idx], bit_load<=1 (asserted next cycle, 1 cycle)
//                 -> WAIT_BUSY.
//     WAIT_BUSY : bit_done=0 -> WAIT_DONE (controller acknowledged the word).
//     WAIT_DONE : bit_done=1 -> idx==NUM_LEDS-1 ? LATCH (counter=0) :
//                 LOAD (idx+1).
//     LATCH     : bit_load stays 0; counter increments each cycle; at
//                 counter==LATCH_CYC-1 -> IDLE with frame_done=1 for that cycle.
//   start outside IDLE is ignored (not queued). start held high gives
//     back-to-back frames: IDLE lasts exactly 1 cycle between them.
//   Latency: start high in IDLE -> bit_load high 2 cycles later. bit_done
//     rising in WAIT_DONE -> next bit_load 2 cycles later.
//   Counter width: $clog2(LATCH_CYC+1); no wrap possible. idx never exceeds
//     NUM_LEDS-1.
//   Sequencer never reorders bits; MSB-first shifting is BitController's job.
// TESTING (bench uses a behavioural BitController model: done falls 1 cycle
//   after bit_load and rises 288 cycles later; NUM_LEDS=3, F_CLK=12 MHz)
//   1. Reset, then idle 100 cycles -> all outputs 0, busy=0, no bit_load.
//   2. Write 0xFF0000,0x00FF00,0x0000FF to addr 0..2, pulse start -> three
//      bit_load pulses carrying those words in order, then 3600 cycles with
//      no bit_load, then one frame_done pulse; busy falls with it.
//   3. Pulse start during WAIT_DONE and during LATCH -> ignored, exactly 3
//      loads per frame; start held high -> frames repeat, 1 IDLE cycle between.
//   4. During pixel 0 transfer, write addr 2 = 0x123456 and addr 0 = 0xABCDEF
//      -> this frame sends 0x123456 for pixel 2 and the old word for pixel 0;
//      next frame sends 0xABCDEF.
//   5. Assert reset in WAIT_DONE of pixel 1 -> outputs return to 0
//      asynchronously, buffer reads 0; a following start sends three 0x000000.
//   6. wr_en with wr_addr=3 (out of range) -> buffer unchanged, frame words same.

Source files
------------

// File: rtl/ws2812_strip_sequencer.sv
// Frame-level WS2812 driver: streams a NUM_LEDS x 24-bit pixel buffer to a
// downstream BitController one word at a time, then holds the latch period.
module ws2812_strip_sequencer #(
    parameter int unsigned F_CLK    = 12_000_000,
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned LATCH_US = 300,
    localparam int unsigned AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          start,
    output logic [23:0]   bit_data,
    output logic          bit_load,
    input  logic          bit_done,
    output logic          busy,
    output logic          frame_done
);

    localparam int unsigned LATCH_CYC = F_CLK / 1_000_000 * LATCH_US;
    localparam int unsigned CW        = $clog2(LATCH_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        LATCH
    } state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [23:0]   pix [NUM_LEDS];

    // Buffer writes are independent of the FSM; LOAD samples the old word on a
    // same-cycle write, so a write to the pixel being loaded lands next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            bit_data   <= '0;
            bit_load   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                pix[i] <= '0;
            end
        end else begin
            bit_load   <= 1'b0;
            frame_done <= 1'b0;

            if (wr_en && (32'(wr_addr) < NUM_LEDS)) begin
                pix[wr_addr] <= wr_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    bit_data <= pix[idx];
                    bit_load <= 1'b1;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!bit_done) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bit_done) begin
                        if (idx == AW'(NUM_LEDS - 1)) begin
                            state <= LATCH;
                            cnt   <= '0;
                        end else begin
                            state <= LOAD;
                            idx   <= idx + AW'(1);
                        end
                    end
                end
                LATCH: begin
                    if (cnt == CW'(LATCH_CYC - 1)) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_strip_sequencer.sv
// Bench for ws2812_strip_sequencer with a behavioural BitController
// (done falls 1 cycle after bit_load, rises 288 cycles later).
module tb_ws2812_strip_sequencer;

    localparam int unsigned N_LEDS    = 3;
    localparam int unsigned LATCH_CYC = 3600;  // 12 MHz * 300 us
    localparam int unsigned FRAME_MAX = 6000;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic        start;
    logic [23:0] bit_data;
    logic        bit_load;
    logic        bit_done;
    logic        busy;
    logic        frame_done;

    ws2812_strip_sequencer #(
        .F_CLK   (12_000_000),
        .NUM_LEDS(N_LEDS),
        .LATCH_US(300)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .bit_data  (bit_data),
        .bit_load  (bit_load),
        .bit_done  (bit_done),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // BitController model
    int sh_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_done <= 1'b1;
            sh_cnt   <= 0;
        end else if (bit_load) begin
            bit_done <= 1'b0;
            sh_cnt   <= 287;
        end else if (!bit_done) begin
            if (sh_cnt == 0) bit_done <= 1'b1;
            else             sh_cnt   <= sh_cnt - 1;
        end
    end

    // Monitor, sampling on the falling edge
    logic [23:0] rx[$];
    int cyc, load_cnt, fd_cnt, first_load_cyc, fd_cyc, done_rise_cyc;
    int idle_run, last_idle;
    logic fd_busy, prev_done;

    initial begin
        cyc = 0; load_cnt = 0; fd_cnt = 0; first_load_cyc = 0; fd_cyc = 0;
        done_rise_cyc = 0; idle_run = 0; last_idle = 0; fd_busy = 1'b0;
        prev_done = 1'b1;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bit_load) begin
            rx.push_back(bit_data);
            if (load_cnt == 0) first_load_cyc = cyc;
            load_cnt = load_cnt + 1;
        end
        if (frame_done) begin
            fd_cnt  = fd_cnt + 1;
            fd_cyc  = cyc;
            fd_busy = busy;
        end
        if (bit_done && !prev_done) done_rise_cyc = cyc;
        prev_done = bit_done;
        if (!busy) begin
            idle_run = idle_run + 1;
        end else begin
            if (idle_run != 0) last_idle = idle_run;
            idle_run = 0;
        end
    end

    int total, bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] word_at(input int i);
        return (i < rx.size()) ? rx[i] : 24'hBAD0BD;
    endfunction

    task automatic clear_mon();
        rx.delete();
        load_cnt = 0;
        fd_cnt   = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_loads(input int n);
        int k = 0;
        while (load_cnt < n && k < int'(FRAME_MAX)) begin
            @(posedge clk); k++;
        end
        if (load_cnt < n) chk("load_timeout", 32'(load_cnt), 32'(n));
    endtask

    task automatic wait_fd(input int n);
        int k = 0;
        while (fd_cnt < n && k < int'(FRAME_MAX) * n) begin
            @(posedge clk); k++;
        end
        if (fd_cnt < n) chk("frame_timeout", 32'(fd_cnt), 32'(n));
        repeat (3) @(posedge clk);
    endtask

    task automatic chk_words(input string tag, input int base,
                             input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2);
        chk({tag, "_pix0"}, 32'(word_at(base)),     32'(e0));
        chk({tag, "_pix1"}, 32'(word_at(base + 1)), 32'(e1));
        chk({tag, "_pix2"}, 32'(word_at(base + 2)), 32'(e2));
    endtask

    task automatic run_frame(input string tag,
                             input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2);
        int exp_first;
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1;
        exp_first = cyc + 1 + 2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_fd(1);
        chk_words(tag, 0, e0, e1, e2);
        chk({tag, "_loads"},     32'(load_cnt),                32'(N_LEDS));
        chk({tag, "_fdone"},     32'(fd_cnt),                  32'd1);
        chk({tag, "_latency"},   32'(first_load_cyc),          32'(exp_first));
        chk({tag, "_latch_gap"}, 32'(fd_cyc - done_rise_cyc),  32'(LATCH_CYC + 1));
        chk({tag, "_busy_fd"},   32'(fd_busy),                 32'd0);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [23:0] data;
        logic [23:0] e0, e1, e2;
    } vec_t;

    vec_t tbl[5];

    initial begin
        total = 0; bad = 0;
        clk = 1'b0; reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;

        // Cumulative buffer writes, one frame per vector; addr 3 is out of range.
        tbl[0] = '{2'd0, 24'hFF0000, 24'hFF0000, 24'h000000, 24'h000000};
        tbl[1] = '{2'd1, 24'h00FF00, 24'hFF0000, 24'h00FF00, 24'h000000};
        tbl[2] = '{2'd2, 24'h0000FF, 24'hFF0000, 24'h00FF00, 24'h0000FF};
        tbl[3] = '{2'd3, 24'h777777, 24'hFF0000, 24'h00FF00, 24'h0000FF};
        tbl[4] = '{2'd1, 24'hA5A5A5, 24'hFF0000, 24'hA5A5A5, 24'h0000FF};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        repeat (100) @(posedge clk);
        #1;
        chk("idle_loads",    32'(load_cnt),   32'd0);
        chk("idle_busy",     32'(busy),       32'd0);
        chk("idle_bit_data", 32'(bit_data),   32'd0);
        chk("idle_bit_load", 32'(bit_load),   32'd0);
        chk("idle_fdone",    32'(fd_cnt),     32'd0);

        for (int i = 0; i < 5; i++) begin
            wr(tbl[i].addr, tbl[i].data);
            run_frame($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2);
        end
        wr(2'd1, 24'h00FF00);

        // start during WAIT_DONE and during LATCH is dropped
        clear_mon();
        pulse_start();
        wait_loads(1);
        repeat (50) @(posedge clk);
        pulse_start();
        wait_loads(3);
        repeat (1500) @(posedge clk);
        pulse_start();
        wait_fd(1);
        repeat (20) @(posedge clk);
        #1;
        chk("ign_loads", 32'(load_cnt), 32'd3);
        chk("ign_fdone", 32'(fd_cnt),   32'd1);
        chk("ign_busy",  32'(busy),     32'd0);

        // start held high: back-to-back frames, one IDLE cycle between
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1;
        wait_fd(1);
        #1 start = 1'b0;
        wait_fd(2);
        chk("b2b_loads", 32'(load_cnt),  32'd6);
        chk("b2b_idle",  32'(last_idle), 32'd1);
        chk_words("b2b_f1", 0, 24'hFF0000, 24'h00FF00, 24'h0000FF);
        chk_words("b2b_f2", 3, 24'hFF0000, 24'h00FF00, 24'h0000FF);

        // writes during pixel 0: pixel 2 this frame, pixel 0 next frame
        clear_mon();
        pulse_start();
        wait_loads(1);
        repeat (10) @(posedge clk);
        wr(2'd2, 24'h123456);
        wr(2'd0, 24'hABCDEF);
        wait_fd(1);
        chk_words("midwr", 0, 24'hFF0000, 24'h00FF00, 24'h123456);
        run_frame("midwr_next", 24'hABCDEF, 24'h00FF00, 24'h123456);

        // reset in WAIT_DONE of pixel 1 aborts and clears the buffer
        clear_mon();
        pulse_start();
        wait_loads(2);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        chk("rst_bit_data", 32'(bit_data),                      32'd0);
        chk("rst_ctrl",     32'({bit_load, busy, frame_done}),  32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        chk("rst_no_resume", 32'(busy), 32'd0);
        run_frame("post_rst", 24'h000000, 24'h000000, 24'h000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
